// File: rtl/zmem_ctrl.sv
// Z80 memory-cycle controller: selects the pager window addressed by za[15:14], routes the
// cycle to the ROM or to the DRAM arbiter, and serves repeat reads from a one-word cache.
module zmem_ctrl #(
  parameter int unsigned ROM_PAGE_BITS = 5
) (
  input  logic                        fclk,
  input  logic                        rst,
  input  logic                        zpos,
  input  logic                        zneg,
  input  logic [15:0]                 za,
  input  logic [7:0]                  zd,
  input  logic                        mreq_n,
  input  logic                        rd_n,
  input  logic                        wr_n,
  input  logic                        rfsh_n,
  input  logic [31:0]                 pages,
  input  logic [3:0]                  romnram,
  output logic                        rom_cs_n,
  output logic [14+ROM_PAGE_BITS-1:0] rom_addr,
  output logic                        dram_req,
  output logic                        dram_rnw,
  output logic [20:0]                 dram_addr,
  output logic [1:0]                  dram_bsel,
  output logic [7:0]                  dram_wrdata,
  input  logic                        dram_stb,
  input  logic [15:0]                 dram_rddata,
  output logic [7:0]                  zd_out,
  output logic                        zd_ena,
  output logic                        zwait
);

  localparam int unsigned RA_W   = 14 + ROM_PAGE_BITS;
  localparam int unsigned DA_W   = 21;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROM,
    S_RD_REQ,
    S_WR_REQ,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic                served_q, served_d;
  logic                za0_q, za0_d;

  logic                rom_cs_n_d;
  logic [RA_W-1:0]     rom_addr_d;
  logic                dram_req_d;
  logic                dram_rnw_d;
  logic [DA_W-1:0]     dram_addr_d;
  logic [1:0]          dram_bsel_d;
  logic [BYTE_W-1:0]   dram_wrdata_d;
  logic [BYTE_W-1:0]   zd_out_d;
  logic                zd_ena_d;

  logic                cache_valid_q, cache_valid_d;
  logic [DA_W-1:0]     cache_tag_q, cache_tag_d;
  logic [WORD_W-1:0]   cache_data_q, cache_data_d;

  logic [1:0]          win;
  logic [BYTE_W-1:0]   win_page;
  logic                win_rom;
  logic [DA_W-1:0]     word_addr;
  logic                is_rd;
  logic                trig;
  logic                cache_hit;
  logic                wr_merge;
  logic [WORD_W-1:0]   merged_word;
  logic                unused_inputs;

  // Window decode for the cycle currently on the bus
  assign win       = za[15:14];
  assign win_page  = pages[{win, 3'b000} +: BYTE_W];
  assign win_rom   = romnram[win];
  assign word_addr = {win_page, za[13:1]};
  assign is_rd     = ~rd_n;

  assign trig = zneg & ~mreq_n & rfsh_n & (~rd_n | ~wr_n) & ~served_q;

  assign cache_hit = cache_valid_q && (cache_tag_q == word_addr);

  // A completed write keeps the cached word coherent when it targets the same word
  assign wr_merge    = ~dram_rnw && cache_valid_q && (cache_tag_q == dram_addr);
  assign merged_word = za0_q ? {dram_wrdata, cache_data_q[7:0]}
                             : {cache_data_q[15:8], dram_wrdata};

  assign zwait = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);

  // The Z80 clock phase strobe and the unused high page bits carry no meaning here
  assign unused_inputs = ^{zpos, win_page[BYTE_W-1:ROM_PAGE_BITS]};

  always_comb begin
    state_d       = state_q;
    served_d      = mreq_n ? 1'b0 : served_q;
    za0_d         = za0_q;
    rom_cs_n_d    = rom_cs_n;
    rom_addr_d    = rom_addr;
    dram_req_d    = dram_req;
    dram_rnw_d    = dram_rnw;
    dram_addr_d   = dram_addr;
    dram_bsel_d   = dram_bsel;
    dram_wrdata_d = dram_wrdata;
    zd_out_d      = zd_out;
    zd_ena_d      = zd_ena;
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          served_d = 1'b1;
          if (win_rom) begin
            rom_cs_n_d = 1'b0;
            rom_addr_d = {win_page[ROM_PAGE_BITS-1:0], za[13:0]};
            state_d    = S_ROM;
          end else if (is_rd && cache_hit) begin
            zd_out_d = za[0] ? cache_data_q[15:8] : cache_data_q[7:0];
            zd_ena_d = 1'b1;
            state_d  = S_HOLD;
          end else begin
            dram_req_d  = 1'b1;
            dram_rnw_d  = is_rd;
            dram_addr_d = word_addr;
            za0_d       = za[0];
            if (is_rd) begin
              dram_bsel_d = 2'b11;
              state_d     = S_RD_REQ;
            end else begin
              dram_bsel_d   = za[0] ? 2'b10 : 2'b01;
              dram_wrdata_d = zd;
              state_d       = S_WR_REQ;
            end
          end
        end
      end

      S_ROM: begin
        if (mreq_n) begin
          rom_cs_n_d = 1'b1;
          state_d    = S_IDLE;
        end
      end

      // Strobe wins over a simultaneous mreq_n release
      S_RD_REQ: begin
        if (dram_stb) begin
          cache_valid_d = 1'b1;
          cache_tag_d   = dram_addr;
          cache_data_d  = dram_rddata;
          zd_out_d      = za0_q ? dram_rddata[15:8] : dram_rddata[7:0];
          zd_ena_d      = 1'b1;
          dram_req_d    = 1'b0;
          state_d       = S_HOLD;
        end else if (mreq_n) begin
          state_d = S_DRAIN;
        end
      end

      S_WR_REQ: begin
        if (dram_stb) begin
          dram_req_d = 1'b0;
          state_d    = S_HOLD;
          if (wr_merge) begin
            cache_data_d = merged_word;
          end
        end else if (mreq_n) begin
          state_d = S_DRAIN;
        end
      end

      S_HOLD: begin
        if (mreq_n) begin
          zd_ena_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      // Aborted access: let the arbiter finish, drop read data, still merge writes
      S_DRAIN: begin
        if (dram_stb) begin
          dram_req_d = 1'b0;
          state_d    = S_IDLE;
          if (wr_merge) begin
            cache_data_d = merged_word;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      served_q      <= 1'b0;
      za0_q         <= 1'b0;
      rom_cs_n      <= 1'b1;
      rom_addr      <= '0;
      dram_req      <= 1'b0;
      dram_rnw      <= 1'b1;
      dram_addr     <= '0;
      dram_bsel     <= 2'b11;
      dram_wrdata   <= '0;
      zd_out        <= '0;
      zd_ena        <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      served_q      <= served_d;
      za0_q         <= za0_d;
      rom_cs_n      <= rom_cs_n_d;
      rom_addr      <= rom_addr_d;
      dram_req      <= dram_req_d;
      dram_rnw      <= dram_rnw_d;
      dram_addr     <= dram_addr_d;
      dram_bsel     <= dram_bsel_d;
      dram_wrdata   <= dram_wrdata_d;
      zd_out        <= zd_out_d;
      zd_ena        <= zd_ena_d;
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
    end
  end

endmodule

// File: tb/tb_zmem_ctrl.sv
// Bench for zmem_ctrl: transaction-level model predicts every output each cycle, plus
// literal expectations for the reference scenarios and a randomized transaction stream.
module tb_zmem_ctrl;

  logic        fclk = 1'b0;
  logic        rst = 1'b1;
  logic        zpos = 1'b0;
  logic        zneg = 1'b0;
  logic [15:0] za = 16'h0;
  logic [7:0]  zd = 8'h0;
  logic        mreq_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        rfsh_n = 1'b1;
  logic [31:0] pages = 32'h0;
  logic [3:0]  romnram = 4'h0;
  logic        rom_cs_n;
  logic [18:0] rom_addr;
  logic        dram_req;
  logic        dram_rnw;
  logic [20:0] dram_addr;
  logic [1:0]  dram_bsel;
  logic [7:0]  dram_wrdata;
  logic        dram_stb = 1'b0;
  logic [15:0] dram_rddata = 16'h0;
  logic [7:0]  zd_out;
  logic        zd_ena;
  logic        zwait;

  zmem_ctrl #(.ROM_PAGE_BITS(5)) dut (
    .fclk(fclk), .rst(rst), .zpos(zpos), .zneg(zneg), .za(za), .zd(zd),
    .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
    .pages(pages), .romnram(romnram),
    .rom_cs_n(rom_cs_n), .rom_addr(rom_addr),
    .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_addr(dram_addr),
    .dram_bsel(dram_bsel), .dram_wrdata(dram_wrdata),
    .dram_stb(dram_stb), .dram_rddata(dram_rddata),
    .zd_out(zd_out), .zd_ena(zd_ena), .zwait(zwait)
  );

  always #5 fclk = ~fclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected output state, updated by the driver right after each active edge
  logic        exp_rom_cs_n = 1'b1;
  logic [18:0] exp_rom_addr = '0;
  logic        exp_req = 1'b0;
  logic        exp_rnw = 1'b1;
  logic [20:0] exp_addr = '0;
  logic [1:0]  exp_bsel = 2'b11;
  logic [7:0]  exp_wrdata = '0;
  logic [7:0]  exp_zd_out = '0;
  logic        exp_zd_ena = 1'b0;
  logic        exp_zwait = 1'b0;

  // Reference one-word cache
  bit          m_valid = 1'b0;
  logic [20:0] m_tag = '0;
  logic [15:0] m_data = '0;

  // Observations captured during one transaction for literal checks
  bit          cap_rom, cap_req, cap_zd_ena;
  logic [18:0] cap_rom_addr;
  logic [20:0] cap_addr;
  logic [1:0]  cap_bsel;
  logic [7:0]  cap_zd_out;
  int          zw_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge fclk) begin
    chk("rom_cs_n", 32'(rom_cs_n), 32'(exp_rom_cs_n));
    if (!exp_rom_cs_n) chk("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
    chk("dram_req", 32'(dram_req), 32'(exp_req));
    if (exp_req) begin
      chk("dram_rnw", 32'(dram_rnw), 32'(exp_rnw));
      chk("dram_addr", 32'(dram_addr), 32'(exp_addr));
      chk("dram_bsel", 32'(dram_bsel), 32'(exp_bsel));
      if (!exp_rnw) chk("dram_wrdata", 32'(dram_wrdata), 32'(exp_wrdata));
    end
    chk("zd_ena", 32'(zd_ena), 32'(exp_zd_ena));
    if (exp_zd_ena) chk("zd_out", 32'(zd_out), 32'(exp_zd_out));
    chk("zwait", 32'(zwait), 32'(exp_zwait));
  end

  task automatic step();
    @(posedge fclk);
    #1;
    if (!rom_cs_n) begin cap_rom = 1'b1; cap_rom_addr = rom_addr; end
    if (dram_req && !cap_req) begin cap_req = 1'b1; cap_addr = dram_addr; cap_bsel = dram_bsel; end
    if (zd_ena) begin cap_zd_ena = 1'b1; cap_zd_out = zd_out; end
    if (zwait) zw_cnt++;
  endtask

  task automatic clear_cap();
    cap_rom = 1'b0; cap_req = 1'b0; cap_zd_ena = 1'b0;
    cap_rom_addr = '0; cap_addr = '0; cap_bsel = '0; cap_zd_out = '0; zw_cnt = 0;
  endtask

  task automatic set_exp_reset();
    exp_rom_cs_n = 1'b1; exp_rom_addr = '0; exp_req = 1'b0; exp_rnw = 1'b1;
    exp_addr = '0; exp_bsel = 2'b11; exp_wrdata = '0; exp_zd_out = '0;
    exp_zd_ena = 1'b0; exp_zwait = 1'b0; m_valid = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_rom_cs_n", 32'(rom_cs_n), 32'h1);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_dram_req", 32'(dram_req), 32'h0);
    chk("rst_dram_rnw", 32'(dram_rnw), 32'h1);
    chk("rst_dram_addr", 32'(dram_addr), 32'h0);
    chk("rst_dram_bsel", 32'(dram_bsel), 32'h3);
    chk("rst_dram_wrdata", 32'(dram_wrdata), 32'h0);
    chk("rst_zd_out", 32'(zd_out), 32'h0);
    chk("rst_zd_ena", 32'(zd_ena), 32'h0);
    chk("rst_zwait", 32'(zwait), 32'h0);
  endtask

  task automatic bus_release();
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  // One Z80 memory cycle; dly = strobe cycle index after dram_req, abort_at = cycle mreq_n rises (-1 none)
  task automatic z_cycle(input logic [15:0] a, input bit wr, input logic [7:0] d,
                         input int dly, input int abort_at, input logic [15:0] rdw);
    logic [1:0]  w;
    logic [7:0]  pg;
    logic [20:0] waddr;
    bit          aborted;
    w = a[15:14];
    pg = pages[{w, 3'b000} +: 8];
    waddr = {pg, a[13:1]};
    aborted = 1'b0;
    clear_cap();
    za = a; zd = d; mreq_n = 1'b0; rd_n = wr; wr_n = !wr;
    step();
    zneg = 1'b1; step(); zneg = 1'b0;
    if (romnram[w]) begin
      exp_rom_cs_n = 1'b0; exp_rom_addr = {pg[4:0], a[13:0]};
      zneg = 1'b1; step(); zneg = 1'b0; step();
      bus_release(); step(); exp_rom_cs_n = 1'b1; step();
    end else if (!wr && m_valid && m_tag == waddr) begin
      exp_zd_ena = 1'b1; exp_zd_out = a[0] ? m_data[15:8] : m_data[7:0];
      zneg = 1'b1; step(); zneg = 1'b0; step();
      bus_release(); step(); exp_zd_ena = 1'b0; step();
    end else begin
      exp_req = 1'b1; exp_rnw = !wr; exp_addr = waddr;
      exp_bsel = wr ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
      if (wr) exp_wrdata = d;
      exp_zwait = 1'b1;
      for (int c = 0; c <= dly; c++) begin
        if (c == abort_at) bus_release();
        if (c == dly) begin dram_stb = 1'b1; dram_rddata = rdw; end
        step();
        dram_stb = 1'b0;
        if (c == dly) begin
          exp_req = 1'b0; exp_zwait = 1'b0;
          if (wr) begin
            if (m_valid && m_tag == waddr) begin
              if (a[0]) m_data[15:8] = d; else m_data[7:0] = d;
            end
          end else if (!aborted) begin
            m_valid = 1'b1; m_tag = waddr; m_data = rdw;
            exp_zd_ena = 1'b1; exp_zd_out = a[0] ? rdw[15:8] : rdw[7:0];
          end
        end else if (c == abort_at) begin
          aborted = 1'b1; exp_zwait = 1'b0;
        end
      end
      if (!mreq_n) begin step(); bus_release(); end
      step(); exp_zd_ena = 1'b0; step();
    end
  endtask

  task automatic refresh_cycle(input logic [15:0] a);
    clear_cap();
    za = a; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
    step();
    zneg = 1'b1; step(); zneg = 1'b0; step();
    bus_release(); rfsh_n = 1'b1; step();
  endtask

  initial begin
    logic [15:0] ra;
    logic [1:0]  rw;
    logic [2:0]  roff;
    bit          rwr;
    int          rdly, rab;
    set_exp_reset();
    #12;
    chk_reset_vals();
    @(posedge fclk); #1; rst = 1'b0;
    step();

    pages = {8'h1F, 8'h02, 8'h11, 8'hFE};
    romnram = 4'b0001;

    z_cycle(16'h1234, 1'b0, 8'h00, 0, -1, 16'h0);
    chk("rom_seen", 32'(cap_rom), 32'h1);
    chk("rom_addr_lit", 32'(cap_rom_addr), 32'({5'h1E, 14'h1234}));
    chk("rom_no_req", 32'(cap_req), 32'h0);

    z_cycle(16'h8001, 1'b0, 8'h00, 3, -1, 16'hA55A);
    chk("miss_addr", 32'(cap_addr), 32'({8'h02, 13'h0000}));
    chk("miss_zd_ena", 32'(cap_zd_ena), 32'h1);
    chk("miss_zd_out", 32'(cap_zd_out), 32'hA5);
    chk("miss_zwait_cycles", 32'(zw_cnt), 32'd4);

    z_cycle(16'h8000, 1'b0, 8'h00, 0, -1, 16'h0);
    chk("hit_no_req", 32'(cap_req), 32'h0);
    chk("hit_zd_out", 32'(cap_zd_out), 32'h5A);
    chk("hit_zwait_cycles", 32'(zw_cnt), 32'd0);

    z_cycle(16'h8001, 1'b1, 8'h3C, 1, -1, 16'h0);
    chk("wr_req", 32'(cap_req), 32'h1);
    chk("wr_bsel", 32'(cap_bsel), 32'h2);
    z_cycle(16'h8001, 1'b0, 8'h00, 0, -1, 16'h0);
    chk("merge_no_req", 32'(cap_req), 32'h0);
    chk("merge_zd_out", 32'(cap_zd_out), 32'h3C);

    z_cycle(16'hC000, 1'b0, 8'h00, 3, 1, 16'hBEEF);
    chk("abort_req", 32'(cap_req), 32'h1);
    chk("abort_no_zd_ena", 32'(cap_zd_ena), 32'h0);
    z_cycle(16'hC000, 1'b0, 8'h00, 0, -1, 16'h4321);
    chk("after_abort_miss", 32'(cap_req), 32'h1);
    chk("min_miss_zwait", 32'(zw_cnt), 32'd1);
    chk("after_abort_zd_out", 32'(cap_zd_out), 32'h21);

    z_cycle(16'h8002, 1'b0, 8'h00, 2, 2, 16'h1234);
    chk("simul_zd_ena", 32'(cap_zd_ena), 32'h1);
    chk("simul_zd_out", 32'(cap_zd_out), 32'h34);
    z_cycle(16'h8003, 1'b0, 8'h00, 0, -1, 16'h0);
    chk("simul_hit_no_req", 32'(cap_req), 32'h0);
    chk("simul_hit_zd_out", 32'(cap_zd_out), 32'h12);

    z_cycle(16'h8003, 1'b1, 8'h77, 2, 0, 16'h0);
    z_cycle(16'h8003, 1'b0, 8'h00, 0, -1, 16'h0);
    chk("abort_merge_no_req", 32'(cap_req), 32'h0);
    chk("abort_merge_zd_out", 32'(cap_zd_out), 32'h77);

    refresh_cycle(16'h0100);
    chk("rfsh_no_req", 32'(cap_req), 32'h0);
    chk("rfsh_no_rom", 32'(cap_rom), 32'h0);
    chk("rfsh_no_zd_ena", 32'(cap_zd_ena), 32'h0);
    z_cycle(16'h8002, 1'b0, 8'h00, 0, -1, 16'h0);
    chk("rfsh_cache_kept", 32'(cap_req), 32'h0);

    // Reset in the middle of a read miss
    clear_cap();
    za = 16'h8004; mreq_n = 1'b0; rd_n = 1'b0;
    step();
    zneg = 1'b1; step(); zneg = 1'b0;
    exp_req = 1'b1; exp_rnw = 1'b1; exp_addr = {8'h02, 13'h0002}; exp_bsel = 2'b11; exp_zwait = 1'b1;
    step();
    chk("pre_reset_req", 32'(cap_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals();
    set_exp_reset();
    bus_release();
    step(); step();
    rst = 1'b0;
    step();
    z_cycle(16'h8002, 1'b0, 8'h00, 1, -1, 16'h5566);
    chk("post_reset_miss", 32'(cap_req), 32'h1);

    for (int t = 0; t < 150; t++) begin
      if (t % 20 == 0) begin
        for (int w = 0; w < 4; w++) begin
          pages[8*w +: 8] = 8'($urandom_range(0, 3));
          romnram[w] = ($urandom_range(0, 3) == 0);
        end
      end
      if ($urandom_range(0, 9) == 0) begin
        refresh_cycle(16'($urandom));
      end else begin
        rw = 2'($urandom_range(0, 3));
        roff = 3'($urandom_range(0, 7));
        ra = {rw, 11'd0, roff};
        rwr = ($urandom_range(0, 2) == 0);
        rdly = int'($urandom_range(0, 4));
        rab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, rdly)) : -1;
        z_cycle(ra, rwr, 8'($urandom), rdly, rab, 16'($urandom));
      end
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
